// File: rtl/fl_head_ckpt.sv
`default_nettype none
// ============================================================================
// Module      : fl_head_ckpt
// Description : Branch checkpoint table that snapshots the free-list head on
//               each branch dispatch, retires resolved branches in order and
//               issues a one-cycle recover pulse carrying the saved head on a
//               mispredict.
// Revision    : 1.0 - initial release
// ============================================================================
module fl_head_ckpt #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 2,
    parameter int HEAD_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_dispatch_en_i,
    input  logic [HEAD_W-1:0] fl_head_i,
    input  logic              br_resolve_en_i,
    input  logic [TAG_W-1:0]  br_tag_i,
    input  logic              br_mispredict_i,
    output logic              ckpt_ack_o,
    output logic [TAG_W-1:0]  br_tag_o,
    output logic              full_o,
    output logic [TAG_W:0]    cnt_o,
    output logic              rc_en_o,
    output logic [HEAD_W-1:0] rc_head_o
);

    localparam logic [TAG_W:0] c_DEPTH_CNT = DEPTH[TAG_W:0];

    logic [HEAD_W-1:0] head_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  resolved_q, resolved_d;
    logic [TAG_W-1:0]  oldest_q, oldest_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [TAG_W:0]    cnt_q, cnt_d;
    logic              rc_en_q;
    logic [HEAD_W-1:0] rc_head_q;

    logic              w_mis_req;
    logic              w_mis_ok;
    logic              w_cor_ok;
    logic              w_free;
    logic              w_ack;
    logic [TAG_W-1:0]  w_dist;
    logic [TAG_W:0]    w_young;

    // A mispredict request blocks dispatch even if its tag turns out invalid;
    // the acknowledge is kept simple and the requester simply retries.
    assign w_mis_req = br_resolve_en_i & br_mispredict_i;
    assign w_mis_ok  = w_mis_req & valid_q[br_tag_i];
    assign w_cor_ok  = br_resolve_en_i & ~br_mispredict_i & valid_q[br_tag_i];
    // The oldest entry is not freed when the mispredict itself flushes it.
    assign w_free    = valid_q[oldest_q] & resolved_q[oldest_q]
                       & ~(w_mis_ok & (br_tag_i == oldest_q));
    assign w_ack     = br_dispatch_en_i & ~full_o & ~w_mis_req & ~rc_en_q;
    // Distance of the mispredicted tag from the oldest entry, and the number
    // of entries from that tag up to the youngest (the ones to flush).
    assign w_dist    = br_tag_i - oldest_q;
    assign w_young   = cnt_q - {1'b0, w_dist};

    assign ckpt_ack_o = w_ack;
    assign br_tag_o   = tail_q;
    assign full_o     = (cnt_q == c_DEPTH_CNT);
    assign cnt_o      = cnt_q;
    assign rc_en_o    = rc_en_q;
    assign rc_head_o  = rc_head_q;

    // Next-state computation for occupancy bits, pointers and count.
    always_comb begin : p_next
        logic [TAG_W-1:0] off;
        off        = '0;
        valid_d    = valid_q;
        resolved_d = resolved_q;
        oldest_d   = oldest_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;

        if (w_free) begin
            valid_d[oldest_q]    = 1'b0;
            resolved_d[oldest_q] = 1'b0;
            oldest_d             = oldest_q + 1'b1;
        end

        if (w_cor_ok) begin
            resolved_d[br_tag_i] = 1'b1;
        end

        if (w_ack) begin
            valid_d[tail_q]    = 1'b1;
            resolved_d[tail_q] = 1'b0;
            tail_d             = tail_q + 1'b1;
        end

        if (w_mis_ok) begin
            // Flush every entry whose circular offset from the tag is within
            // the younger span; this also covers the full case (tail==tag).
            for (int i = 0; i < DEPTH; i++) begin
                off = TAG_W'(i) - br_tag_i;
                if ({1'b0, off} < w_young) begin
                    valid_d[i]    = 1'b0;
                    resolved_d[i] = 1'b0;
                end
            end
            tail_d = br_tag_i;
            cnt_d  = {1'b0, w_dist} - {{TAG_W{1'b0}}, w_free};
        end else if (w_ack && !w_free) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!w_ack && w_free) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Control state and recover outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q    <= '0;
            resolved_q <= '0;
            oldest_q   <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            rc_en_q    <= 1'b0;
            rc_head_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            resolved_q <= resolved_d;
            oldest_q   <= oldest_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            rc_en_q    <= w_mis_ok;
            if (w_mis_ok) begin
                rc_head_q <= head_q[br_tag_i];
            end
        end
    end

    // Head snapshot storage, written on allocation and never reset.
    always_ff @(posedge clk) begin
        if (w_ack) begin
            head_q[tail_q] <= fl_head_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fl_head_ckpt.sv
`default_nettype none
// ============================================================================
// Module      : tb_fl_head_ckpt
// Description : Directed table-driven bench for fl_head_ckpt with a few
//               hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fl_head_ckpt;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_i;
    logic [4:0] h_i;
    logic       r_i;
    logic [1:0] t_i;
    logic       m_i;
    logic       ack_o;
    logic [1:0] tag_o;
    logic       full_o;
    logic [2:0] cnt_o;
    logic       rce_o;
    logic [4:0] rch_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst_n;
        logic       d;
        logic [4:0] h;
        logic       r;
        logic [1:0] t;
        logic       m;
        logic       ack;
        logic [1:0] tag;
        logic       full;
        logic [2:0] cnt;
        logic       rce;
        logic [4:0] rch;
    } vec_t;

    vec_t vecs[$];

    fl_head_ckpt #(.DEPTH(4), .TAG_W(2), .HEAD_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .br_dispatch_en_i (d_i),
        .fl_head_i        (h_i),
        .br_resolve_en_i  (r_i),
        .br_tag_i         (t_i),
        .br_mispredict_i  (m_i),
        .ckpt_ack_o       (ack_o),
        .br_tag_o         (tag_o),
        .full_o           (full_o),
        .cnt_o            (cnt_o),
        .rc_en_o          (rce_o),
        .rc_head_o        (rch_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rn, logic d, int h, logic r, int t, logic m,
                                logic ack, int tag, logic full, int cnt,
                                logic rce, int rch);
        vec_t v;
        v.rst_n = rn; v.d = d; v.h = 5'(h); v.r = r; v.t = 2'(t); v.m = m;
        v.ack = ack; v.tag = 2'(tag); v.full = full; v.cnt = 3'(cnt);
        v.rce = rce; v.rch = 5'(rch);
        return v;
    endfunction

    // Drive inputs just after the falling edge and let them settle.
    task automatic drive(logic rn, logic d, int h, logic r, int t, logic m);
        @(negedge clk);
        rst = rn; d_i = d; h_i = 5'(h); r_i = r; t_i = 2'(t); m_i = m;
        #2;
    endtask

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(string nm, logic ack, int tag, logic full, int cnt,
                           logic rce, int rch);
        chk({nm, ".ack"},  int'(ack_o),  int'(ack));
        chk({nm, ".tag"},  int'(tag_o),  tag);
        chk({nm, ".full"}, int'(full_o), int'(full));
        chk({nm, ".cnt"},  int'(cnt_o),  cnt);
        chk({nm, ".rce"},  int'(rce_o),  int'(rce));
        chk({nm, ".rch"},  int'(rch_o),  rch);
    endtask

    initial begin
        int acks;
        int budget;

        rst = 1'b0; d_i = 0; h_i = 0; r_i = 0; t_i = 0; m_i = 0;

        // Reset state, then fill to full, overfill attempt
        vecs.push_back(mk(1,0, 0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1,1, 3,0,0,0, 1,0,0,0,0,0));
        vecs.push_back(mk(1,1, 4,0,0,0, 1,1,0,1,0,0));
        vecs.push_back(mk(1,1, 5,0,0,0, 1,2,0,2,0,0));
        vecs.push_back(mk(1,1, 6,0,0,0, 1,3,0,3,0,0));
        vecs.push_back(mk(1,1, 7,0,0,0, 0,0,1,4,0,0));
        vecs.push_back(mk(1,0, 0,0,0,0, 0,0,1,4,0,0));
        // Mispredict tag 1 with concurrent dispatch, then dispatch during pulse
        vecs.push_back(mk(1,1, 8,1,1,1, 0,0,1,4,0,0));
        vecs.push_back(mk(1,1, 9,0,0,0, 0,1,0,1,1,4));
        vecs.push_back(mk(1,0, 0,0,0,0, 0,1,0,1,0,4));
        // Out-of-order correct resolves: 2, then 0, then 1
        vecs.push_back(mk(1,1,10,0,0,0, 1,1,0,1,0,4));
        vecs.push_back(mk(1,1,11,0,0,0, 1,2,0,2,0,4));
        vecs.push_back(mk(1,0, 0,1,2,0, 0,3,0,3,0,4));
        vecs.push_back(mk(1,0, 0,0,0,0, 0,3,0,3,0,4));
        vecs.push_back(mk(1,0, 0,1,0,0, 0,3,0,3,0,4));
        vecs.push_back(mk(1,0, 0,0,0,0, 0,3,0,3,0,4));
        vecs.push_back(mk(1,0, 0,0,0,0, 0,3,0,2,0,4));
        vecs.push_back(mk(1,0, 0,0,0,0, 0,3,0,2,0,4));
        vecs.push_back(mk(1,0, 0,1,1,0, 0,3,0,2,0,4));
        vecs.push_back(mk(1,0, 0,0,0,0, 0,3,0,2,0,4));
        vecs.push_back(mk(1,0, 0,0,0,0, 0,3,0,1,0,4));
        vecs.push_back(mk(1,0, 0,0,0,0, 0,3,0,0,0,4));
        // Reset with dispatch asserted, then dispatch + mispredict of tag 0
        vecs.push_back(mk(0,1,15,0,0,0, 1,3,0,0,0,4));
        vecs.push_back(mk(1,1,20,0,0,0, 1,0,0,0,0,0));
        vecs.push_back(mk(1,1,21,0,0,0, 1,1,0,1,0,0));
        vecs.push_back(mk(1,1,22,1,0,1, 0,2,0,2,0,0));
        vecs.push_back(mk(1,0, 0,0,0,0, 0,0,0,0,1,20));
        vecs.push_back(mk(1,0, 0,0,0,0, 0,0,0,0,0,20));
        // Wrap: six alloc/resolve/free triples
        for (int k = 0; k < 6; k++) begin
            vecs.push_back(mk(1,1,30+k,0,0,0, 1,k%4,0,0,0,20));
            vecs.push_back(mk(1,0,0,1,k%4,0, 0,(k+1)%4,0,1,0,20));
            vecs.push_back(mk(1,0,0,0,0,0,   0,(k+1)%4,0,1,0,20));
        end
        // Mispredict followed by reset during the recover pulse
        vecs.push_back(mk(1,1,40,0,0,0, 1,2,0,0,0,20));
        vecs.push_back(mk(1,1,41,0,0,0, 1,3,0,1,0,20));
        vecs.push_back(mk(1,0, 0,1,2,1, 0,0,0,2,0,20));
        vecs.push_back(mk(0,0, 0,0,0,0, 0,2,0,0,1,40));
        vecs.push_back(mk(1,0, 0,0,0,0, 0,0,0,0,0,0));
        // Mispredict to an invalid tag is ignored
        vecs.push_back(mk(1,1, 9,1,1,1, 0,0,0,0,0,0));
        vecs.push_back(mk(1,0, 0,0,0,0, 0,0,0,0,0,0));

        drive(0,0,0,0,0,0);
        drive(0,0,0,0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].d, int'(vecs[i].h), vecs[i].r,
                  int'(vecs[i].t), vecs[i].m);
            chk_all($sformatf("vec%0d", i), vecs[i].ack, int'(vecs[i].tag),
                    vecs[i].full, int'(vecs[i].cnt), vecs[i].rce,
                    int'(vecs[i].rch));
        end

        // Mispredict while the oldest entry is freed in the same cycle
        drive(1,1,1,0,0,0);
        drive(1,1,2,0,0,0);
        drive(1,1,3,0,0,0);
        drive(1,0,0,1,0,0);
        drive(1,0,0,1,2,1);
        drive(1,0,0,0,0,0);
        chk_all("mis_free", 0, 2, 0, 1, 1, 3);
        drive(1,0,0,1,1,0);
        drive(1,0,0,0,0,0);
        drive(1,0,0,0,0,0);
        chk("mis_free.drain", int'(cnt_o), 0);

        // Dispatch continuously until full, bounded by a cycle budget
        drive(0,0,0,0,0,0);
        acks   = 0;
        budget = 0;
        drive(1,1,17,0,0,0);
        while (!full_o && budget < 10) begin
            if (ack_o) acks++;
            budget++;
            drive(1,1,17,0,0,0);
        end
        chk("fill.timeout", int'(full_o), 1);
        chk("fill.acks", acks, 4);
        chk("fill.noack", int'(ack_o), 0);
        drive(1,0,0,0,0,0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fl_head_ckpt.md
FL_HEAD_CKPT -- requirements
Module: fl_head_ckpt

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of branch checkpoint entries.
REQ-002 SHALL have parameter TAG_W, default 2, giving the branch tag width (log2 DEPTH).
REQ-003 SHALL have parameter HEAD_W, default 5, giving the width of the free-list head pointer.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-low (rst==0 at a rising edge resets).
REQ-006 SHALL have port br_dispatch_en_i, input, 1 bit: a branch is dispatching this cycle and requests a checkpoint.
REQ-007 SHALL have port fl_head_i, input, HEAD_W bits: the current free-list head pointer, captured on allocation.
REQ-008 SHALL have port br_resolve_en_i, input, 1 bit: a branch resolves this cycle (at most one resolve per cycle).
REQ-009 SHALL have port br_tag_i, input, TAG_W bits: the tag of the resolving branch.
REQ-010 SHALL have port br_mispredict_i, input, 1 bit: qualifies the resolve; 1 means mispredicted, 0 means correct.
REQ-011 SHALL have port ckpt_ack_o, output, 1 bit: the checkpoint is allocated this cycle.
REQ-012 SHALL have port br_tag_o, output, TAG_W bits: the tag assigned to the dispatching branch (current tail index).
REQ-013 SHALL have port full_o, output, 1 bit: all DEPTH entries are occupied.
REQ-014 SHALL have port cnt_o, output, TAG_W+1 bits: the number of occupied entries.
REQ-015 SHALL have port rc_en_o, output, 1 bit: registered one-cycle recover pulse to the free list.
REQ-016 SHALL have port rc_head_o, output, HEAD_W bits: registered head value to be restored into the free list.

Function
REQ-017 SHALL hold per entry: head snapshot (HEAD_W), valid bit, resolved bit; plus pointers oldest and tail (TAG_W, wrap mod DEPTH) and a count (0..DEPTH).
REQ-018 SHALL drive ckpt_ack_o combinationally as br_dispatch_en_i & ~full_o & ~(br_resolve_en_i & br_mispredict_i) & ~rc_en_o.
REQ-019 SHALL drive br_tag_o = tail and full_o = (count == DEPTH) combinationally.
REQ-020 On ckpt_ack_o: entry[tail] SHALL receive fl_head_i, valid=1 and resolved=0, and tail SHALL become tail+1 mod DEPTH.
REQ-021 On correct resolve (br_resolve_en_i=1, br_mispredict_i=0) of a valid tag: entry resolved SHALL become 1; a resolve to an invalid tag SHALL be ignored.
REQ-022 Each cycle, if entry[oldest] is valid and resolved, it SHALL be freed (valid=0, oldest+1 mod DEPTH); at most one entry SHALL be freed per cycle.
REQ-023 On mispredict resolve of a valid tag t: entries t through tail-1 (circular) SHALL be invalidated, and tail SHALL become t.
REQ-024 On mispredict, the next-cycle values SHALL be rc_en_o=1 and rc_head_o=entry[t].head.
REQ-025 In every cycle without a valid mispredict, rc_en_o SHALL be 0 next cycle and rc_head_o SHALL hold its value.
REQ-026 A mispredict to an invalid tag SHALL be ignored entirely: no pulse, no state change.
REQ-027 After a mispredict, count SHALL equal ((t - oldest) mod DEPTH), minus 1 if the oldest entry is freed in the same cycle.
REQ-028 Otherwise count SHALL be +1 on alloc only, -1 on free only, and unchanged on both or neither.
REQ-029 A mispredict SHALL have priority over dispatch in the same cycle; the dispatch is not acked and the requester retries.
REQ-030 While rc_en_o=1, dispatch SHALL NOT be acked, so the free list's dispatch-over-recover priority is never exercised.
REQ-031 Dispatch while full SHALL NOT be acked and SHALL NOT change state.
REQ-032 Alloc and free in the same cycle with count==DEPTH is impossible because ack requires ~full; alloc and free with 0<count<DEPTH SHALL leave count unchanged.

Reset
REQ-033 On rst==0 at a rising edge: all valid and resolved bits SHALL be 0; oldest=0, tail=0, count=0; rc_en_o=0, rc_head_o=0.
REQ-034 Reset SHALL take priority over all simultaneous dispatch and resolve inputs, including mid-recovery, which squashes a pending rc_en_o.
REQ-035 Head snapshot storage need not be reset.

Verification
REQ-036 Reset then 4 dispatches with fl_head_i=3,4,5,6 -> tags 0,1,2,3 acked, full_o=1, cnt_o=4; a 5th dispatch -> ckpt_ack_o=0, state unchanged.
REQ-037 From REQ-036, mispredict tag 1 -> next cycle rc_en_o=1 and rc_head_o=4; tail=1, cnt_o=1; a dispatch during the pulse -> ckpt_ack_o=0.
REQ-038 Correct-resolve tags 2 then 0 out of order -> nothing is freed after tag 2; after tag 0, entry 0 is freed and oldest=1; entry 2 is freed only after tag 1 resolves.
REQ-039 Same-cycle dispatch and mispredict of tag 0 with count=2 -> no ack, rc_head_o=entry0.head, cnt_o=0, tail=0.
REQ-040 Wrap: cycle 6 alloc/resolve/free pairs -> tags 0,1,2,3,0,1 are issued, and cnt_o never exceeds 1.
REQ-041 rst=0 asserted in the cycle after a mispredict -> rc_en_o=0 and cnt_o=0 on the following edge.
